// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus memory responder.
package mips_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } state_t;

    // 33-bit compare so a region ending at the top of the address space still decodes.
    function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [32:0] span);
        logic [32:0] a;
        logic [32:0] lo;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        return (a >= lo) && (a < lo + span);
    endfunction

endpackage

// File: rtl/mips_bus_ram_bank.sv
// One word-addressed memory region: byte-lane synchronous write, combinational read.
module mips_bus_ram_bank #(
  parameter int    WORDS     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] index,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mips_bus_ram_slave.sv
// Avalon-MM memory responder with fixed wait states, two regions and response codes.
module mips_bus_ram_slave
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE      = RESET_VECTOR,
    parameter int          INSTR_WORDS     = 1024,
    parameter logic [31:0] DATA_BASE       = 32'h00001000,
    parameter int          DATA_WORDS      = 1024,
    parameter int          WAIT_CYCLES     = 2,
    parameter string       INSTR_INIT_FILE = "",
    parameter string       DATA_INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic [1:0]  response
);

    localparam int IAW = $clog2(INSTR_WORDS);
    localparam int DAW = $clog2(DATA_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] src_addr;
    logic        src_rd;
    logic        src_wr;
    logic        hit_i;
    logic        hit_d;
    logic [IAW-1:0] idx_i;
    logic [DAW-1:0] idx_d;
    logic [31:0] rdata_i;
    logic [31:0] rdata_d;
    logic [1:0]  resp_next;
    logic [31:0] rdata_next;
    logic        commit;

    // With one wait state READY is entered straight from IDLE, so decode the live request there.
    always_comb begin
        src_addr = addr_q;
        src_rd   = rd_q;
        src_wr   = wr_q;
        if (state == IDLE) begin
            src_addr = address;
            src_rd   = read;
            src_wr   = write;
        end
    end

    always_comb begin
        hit_i = in_region(src_addr, INSTR_BASE, 33'(4 * INSTR_WORDS));
        hit_d = in_region(src_addr, DATA_BASE, 33'(4 * DATA_WORDS));
        idx_i = IAW'((src_addr - INSTR_BASE) >> 2);
        idx_d = DAW'((src_addr - DATA_BASE) >> 2);

        resp_next = RESP_OKAY;
        if ((src_rd && src_wr) || (src_addr[1:0] != 2'b00)) begin
            resp_next = RESP_SLVERR;
        end else if (!hit_i && !hit_d) begin
            resp_next = RESP_DECERR;
        end

        rdata_next = 32'h0;
        if (resp_next == RESP_OKAY && src_rd) begin
            rdata_next = hit_i ? rdata_i : rdata_d;
        end
    end

    // Dropping write before the completing edge cancels the commit.
    assign commit = (state == READY) && wr_q && write && (response == RESP_OKAY);

    mips_bus_ram_bank #(
        .WORDS    (INSTR_WORDS),
        .INIT_FILE(INSTR_INIT_FILE)
    ) u_instr (
        .clk  (clk),
        .we   (commit && hit_i),
        .index(idx_i),
        .be   (be_q),
        .wdata(wdata_q),
        .rdata(rdata_i)
    );

    mips_bus_ram_bank #(
        .WORDS    (DATA_WORDS),
        .INIT_FILE(DATA_INIT_FILE)
    ) u_data (
        .clk  (clk),
        .we   (commit && !hit_i && hit_d),
        .index(idx_d),
        .be   (be_q),
        .wdata(wdata_q),
        .rdata(rdata_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            readdata <= 32'h0;
            response <= RESP_OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    if (read || write) begin
                        addr_q  <= address;
                        wdata_q <= writedata;
                        be_q    <= byteenable;
                        rd_q    <= read;
                        wr_q    <= write;
                        cnt     <= CNT_INIT;
                        if (CNT_INIT == 4'd0) begin
                            state    <= READY;
                            readdata <= rdata_next;
                            response <= resp_next;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= READY;
                        readdata <= rdata_next;
                        response <= resp_next;
                    end
                end
                READY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign waitrequest = (state != READY);

endmodule
